// File: rtl/udp_tx_packer.sv
// udp_tx_packer: buffers an application byte stream and cuts it into UDP payloads for the Ethernet TX engine
module udp_tx_packer #(
  parameter int ADDR_W    = 11,
  parameter int PKT_BYTES = 1024,
  parameter int TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              tx_start_en,
  output logic [15:0]       tx_byte_num,
  input  logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic              udp_tx_done,
  output logic              busy,
  output logic [ADDR_W:0]   level,
  output logic [7:0]        err_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W:0] FULL_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PKT_L = (ADDR_W+1)'(PKT_BYTES);
  localparam logic [IW-1:0] TO_L = IW'(TIMEOUT - 1);
  localparam logic [15:0] PKT_N = 16'(PKT_BYTES);

  typedef enum logic [1:0] {IDLE, START, SEND, WAIT_DONE} state_t;

  state_t            state_q;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [15:0]       sent_q, num_q;
  logic [7:0]        data_q, err_q;
  logic              start_q;
  logic              wr, pop, last_pop;

  assign in_ready    = level_q != FULL_L;
  assign tx_start_en = start_q;
  assign tx_byte_num = num_q;
  assign tx_data     = data_q;
  assign busy        = state_q != IDLE;
  assign level       = level_q;
  assign err_cnt     = err_q;

  // FIFO handshakes, pointer/level next state and the idle timer that triggers partial flushes
  always_comb begin
    wr       = in_valid && in_ready;
    pop      = (state_q == SEND) && tx_req && (sent_q < num_q);
    last_pop = pop && (sent_q + 16'd1 == num_q);
    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = (wr && !pop) ? level_q + 1'b1 : (!wr && pop) ? level_q - 1'b1 : level_q;
    idle_d   = (wr || level_q == '0 || state_q != IDLE) ? '0 : (idle_q == TO_L) ? idle_q : idle_q + 1'b1;
  end

  // Payload storage; contents are meaningless after reset because the pointers restart
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers, occupancy and idle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      idle_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      idle_q   <= idle_d;
    end
  end

  // Frame sequencer with registered start pulse, length, read data and error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      num_q   <= '0;
      sent_q  <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (level_q >= PKT_L) begin
            num_q   <= PKT_N;
            start_q <= 1'b1;
            state_q <= START;
          end else if (level_q != '0 && idle_q == TO_L) begin
            num_q   <= 16'(level_q);
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          sent_q  <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (pop) sent_q <= sent_q + 16'd1;
          if (udp_tx_done) begin
            err_q   <= (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            state_q <= IDLE;
          end else if (last_pop) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (udp_tx_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (pop) data_q <= mem_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_udp_tx_packer.sv
// tb_udp_tx_packer: queue-model scoreboard plus directed frame scenarios for udp_tx_packer
module tb_udp_tx_packer;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, tx_req = 1'b0, udp_tx_done = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, tx_start_en, busy;
  logic [15:0] tx_byte_num;
  logic [7:0]  tx_data, err_cnt;
  logic [11:0] level;

  int n_cmp = 0, n_bad = 0, starts = 0;
  logic [7:0] got[$];

  always #4 clk = ~clk;

  udp_tx_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_req(tx_req), .tx_data(tx_data),
    .udp_tx_done(udp_tx_done), .busy(busy), .level(level), .err_cnt(err_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: the FIFO is a queue, a frame is a byte budget opened by each start pulse
  logic [7:0]  mq[$];
  logic [7:0]  exp_data = 8'd0, exp_err = 8'd0;
  logic [15:0] exp_num = 16'd0;
  int          remaining = 0, prev_size = 0, sz = 0;
  bit          in_frame = 0, start_cyc = 0, ended_prev = 0, m_pop, m_wr;

  always @(negedge clk) begin
    if (tx_start_en) starts++;
    if (!rst_n) begin
      mq.delete();
      exp_data = 8'd0; exp_err = 8'd0; exp_num = 16'd0;
      remaining = 0; prev_size = 0; in_frame = 0; start_cyc = 0; ended_prev = 0;
      chk("rst_start", 32'(tx_start_en), 0);
    end else if (tx_start_en) begin
      chk("start_legal", 32'(!in_frame && !ended_prev && prev_size > 0), 1);
      in_frame = 1; start_cyc = 1;
      exp_num = 16'(prev_size >= 1024 ? 1024 : prev_size);
      remaining = int'(exp_num);
    end else begin
      start_cyc = 0;
    end
    chk("m_level", 32'(level), mq.size());
    chk("m_in_ready", 32'(in_ready), 32'(mq.size() != 2048));
    chk("m_busy", 32'(busy), 32'(in_frame));
    chk("m_tx_data", 32'(tx_data), 32'(exp_data));
    chk("m_err_cnt", 32'(err_cnt), 32'(exp_err));
    chk("m_byte_num", 32'(tx_byte_num), 32'(exp_num));
    if (rst_n) begin
      sz = mq.size();
      ended_prev = 0;
      m_pop = in_frame && !start_cyc && tx_req && remaining > 0;
      m_wr = in_valid && mq.size() != 2048;
      if (in_frame && !start_cyc && udp_tx_done) begin
        if (remaining > 0 && exp_err != 8'hFF) exp_err++;
        in_frame = 0; ended_prev = 1;
      end
      if (m_pop) begin exp_data = mq.pop_front(); remaining--; end
      if (m_wr) mq.push_back(in_data);
      prev_size = sz;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_start(output int t);
    t = 0;
    do begin tick; t++; end while (!tx_start_en && t < 3000);
    chk("start_seen", 32'(tx_start_en), 1);
  endtask

  task automatic pump(input int n);
    got.delete();
    tx_req = 1'b1;
    repeat (n) begin tick; got.push_back(tx_data); end
    tx_req = 1'b0;
  endtask

  task automatic done_pulse;
    udp_tx_done = 1'b1; tick; udp_tx_done = 1'b0;
  endtask

  task automatic write_bytes(input int n, input int mul);
    for (int i = 0; i < n; i++) begin in_valid = 1'b1; in_data = 8'(i * mul); tick; end
    in_valid = 1'b0;
  endtask

  task automatic rst_vals(input string nm);
    chk({nm, "_start"}, 32'(tx_start_en), 0);
    chk({nm, "_num"}, 32'(tx_byte_num), 0);
    chk({nm, "_data"}, 32'(tx_data), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_level"}, 32'(level), 0);
    chk({nm, "_err"}, 32'(err_cnt), 0);
    chk({nm, "_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    int t, e, s0;
    repeat (3) tick;
    rst_vals("reset");
    rst_n = 1'b1; tick;

    // full 1024-byte packet
    write_bytes(1024, 1);
    chk("t1_level", 32'(level), 1024);
    wait_start(t);
    chk("t1_latency", t, 1);
    chk("t1_num", 32'(tx_byte_num), 1024);
    tick;
    chk("t1_one_pulse", 32'(tx_start_en), 0);
    pump(1026);
    e = 0;
    for (int j = 0; j < 1026; j++) if (got[j] !== 8'(j < 1024 ? j : 1023)) e++;
    chk("t1_data", e, 0);
    chk("t1_level0", 32'(level), 0);
    chk("t1_busy_wait", 32'(busy), 1);
    done_pulse;
    chk("t1_busy_done", 32'(busy), 0);
    chk("t1_starts", starts, 1);

    // timeout flush of 5 bytes
    for (int i = 0; i < 5; i++) begin in_valid = 1'b1; in_data = 8'hA1 + 8'(i); tick; end
    in_valid = 1'b0;
    wait_start(t);
    chk("t2_timeout", t, 1000);
    chk("t2_num", 32'(tx_byte_num), 5);
    tick;
    pump(7);
    e = 0;
    for (int j = 0; j < 7; j++) if (got[j] !== 8'hA1 + 8'(j < 5 ? j : 4)) e++;
    chk("t2_data", e, 0);
    done_pulse;

    // overfill with no engine
    for (int i = 0; i <= 2048; i++) begin
      in_valid = 1'b1; in_data = 8'(i); tick;
      if (i == 2047) begin
        chk("t3_ready_full", 32'(in_ready), 0);
        chk("t3_level_full", 32'(level), 2048);
      end
    end
    in_valid = 1'b0;
    chk("t3_drop", 32'(level), 2048);
    chk("t3_num", 32'(tx_byte_num), 1024);

    // simultaneous write and pop at full, then drain across the pointer wrap
    got.delete();
    for (int j = 0; j < 100; j++) begin
      in_valid = 1'b1; in_data = 8'(j) ^ 8'h5A; tx_req = 1'b1; tick; got.push_back(tx_data);
    end
    in_valid = 1'b0; tx_req = 1'b0;
    e = 0;
    for (int j = 0; j < 100; j++) if (got[j] !== 8'(j)) e++;
    chk("t4_head", e, 0);
    chk("t4_level", 32'(level), 2047);
    pump(924);
    done_pulse;
    wait_start(t);
    chk("t4_num2", 32'(tx_byte_num), 1024);
    tick;
    pump(1024);
    e = 0;
    for (int j = 0; j < 1024; j++) if (got[j] !== 8'(j)) e++;
    chk("t4_mid", e, 0);
    done_pulse;
    wait_start(t);
    chk("t4_num3", 32'(tx_byte_num), 99);
    tick;
    pump(99);
    e = 0;
    for (int j = 0; j < 99; j++) if (got[j] !== (8'(j + 1) ^ 8'h5A)) e++;
    chk("t4_wrap_order", e, 0);
    done_pulse;
    chk("t4_empty", 32'(level), 0);

    // early done after 10 pops
    write_bytes(1024, 3);
    wait_start(t);
    tick;
    pump(10);
    done_pulse;
    chk("t5_err", 32'(err_cnt), 1);
    chk("t5_idle", 32'(busy), 0);
    chk("t5_level", 32'(level), 1014);
    wait_start(t);
    chk("t5_num", 32'(tx_byte_num), 1014);
    tick;
    pump(1014);
    chk("t5_resume", 32'(got[0]), 32'h1E);
    chk("t5_last", 32'(got[1013]), 32'hFD);
    done_pulse;
    chk("t5_err_hold", 32'(err_cnt), 1);

    // reset in the middle of SEND
    write_bytes(1024, 1);
    wait_start(t);
    tick;
    pump(5);
    tx_req = 1'b1;
    rst_n = 1'b0;
    #1;
    rst_vals("t6");
    tx_req = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    s0 = starts;
    repeat (1200) tick;
    chk("t6_no_start", starts, s0);
    chk("t6_level", 32'(level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
